// File: rtl/decode_modrm_collector.sv
// Collects opcode, ModR/M, SIB and displacement bytes into one record.
// Record is held until consumed; flush and reset abandon partial work.
module decode_modrm_collector #(
    parameter bit ADDRESS_SIZE_32 = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  opcode,
    output logic        w_in_instruction,
    output logic        w,
    output logic [2:0]  register_sequence_code,
    output logic        has_modrm,
    output logic [1:0]  mod,
    output logic [2:0]  rm,
    output logic        has_sib,
    output logic [7:0]  sib,
    output logic [31:0] disp,
    output logic [1:0]  disp_size,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_OPCODE,
        S_MODRM,
        S_SIB,
        S_DISP,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        w_in;
        logic        w;
        logic [2:0]  rsc;
        logic        has_modrm;
        logic [1:0]  mod;
        logic [2:0]  rm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [31:0] disp;
        logic [1:0]  disp_size;
        logic        illegal;
    } rec_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    rec_t       rec_q, rec_d;

    logic       take;
    logic       op_modrm;
    logic       op_reg;
    logic [1:0] ds_modrm;
    logic [1:0] ds_sib;
    logic       disp_last;

    // Displacement size encoding for a given mod and rm (or SIB base).
    function automatic logic [1:0] dsz(input logic [1:0] m,
                                       input logic [2:0] r);
        logic [1:0] s;
        s = 2'd0;
        if (ADDRESS_SIZE_32) begin
            if (m == 2'd1)                     s = 2'd1;
            else if (m == 2'd2)                s = 2'd3;
            else if (m == 2'd0 && r == 3'd5)   s = 2'd3;
        end else begin
            if (m == 2'd1)                     s = 2'd1;
            else if (m == 2'd2)                s = 2'd2;
            else if (m == 2'd0 && r == 3'd6)   s = 2'd2;
        end
        return s;
    endfunction

    assign byte_ready             = (state_q != S_OUT);
    assign out_valid              = (state_q == S_OUT);
    assign opcode                 = rec_q.opcode;
    assign w_in_instruction       = rec_q.w_in;
    assign w                      = rec_q.w;
    assign register_sequence_code = rec_q.rsc;
    assign has_modrm              = rec_q.has_modrm;
    assign mod                    = rec_q.mod;
    assign rm                     = rec_q.rm;
    assign has_sib                = rec_q.has_sib;
    assign sib                    = rec_q.sib;
    assign disp                   = rec_q.disp;
    assign disp_size              = rec_q.disp_size;
    assign illegal                = rec_q.illegal;

    // Next-state, byte assembly and record field updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_d     = rec_q;
        take      = byte_valid && byte_ready;
        op_modrm  = (byte_data < 8'h40 && !byte_data[2]) ||
                    (byte_data[7:2] == 6'b100010);
        op_reg    = (byte_data[7:5] == 3'b010);
        ds_modrm  = dsz(byte_data[7:6], byte_data[2:0]);
        ds_sib    = dsz(rec_q.mod, byte_data[2:0]);
        disp_last = (rec_q.disp_size == 2'd1) ||
                    (rec_q.disp_size == 2'd2 && cnt_q == 2'd1) ||
                    (rec_q.disp_size == 2'd3 && cnt_q == 2'd3);
        case (state_q)
            S_OPCODE: if (take) begin
                rec_d        = '0;
                rec_d.opcode = byte_data;
                if (op_modrm) begin
                    rec_d.has_modrm = 1'b1;
                    rec_d.w_in      = 1'b1;
                    rec_d.w         = byte_data[0];
                    state_d         = S_MODRM;
                end else if (op_reg) begin
                    rec_d.rsc = byte_data[2:0];
                    state_d   = S_OUT;
                end else begin
                    rec_d.illegal = 1'b1;
                    state_d       = S_OUT;
                end
            end
            S_MODRM: if (take) begin
                rec_d.rsc = byte_data[5:3];
                rec_d.mod = byte_data[7:6];
                rec_d.rm  = byte_data[2:0];
                cnt_d     = 2'd0;
                if (ADDRESS_SIZE_32 && byte_data[7:6] != 2'd3 &&
                    byte_data[2:0] == 3'd4) begin
                    rec_d.has_sib = 1'b1;
                    state_d       = S_SIB;
                end else begin
                    rec_d.disp_size = ds_modrm;
                    state_d = (ds_modrm == 2'd0) ? S_OUT : S_DISP;
                end
            end
            S_SIB: if (take) begin
                rec_d.sib       = byte_data;
                rec_d.disp_size = ds_sib;
                cnt_d           = 2'd0;
                state_d = (ds_sib == 2'd0) ? S_OUT : S_DISP;
            end
            S_DISP: if (take) begin
                cnt_d = cnt_q + 2'd1;
                case (rec_q.disp_size)
                    2'd1: rec_d.disp = {{24{byte_data[7]}}, byte_data};
                    2'd2: begin
                        if (cnt_q == 2'd0)
                            rec_d.disp[7:0] = byte_data;
                        else
                            rec_d.disp = {{16{byte_data[7]}}, byte_data,
                                          rec_q.disp[7:0]};
                    end
                    default: rec_d.disp[{cnt_q, 3'b000} +: 8] = byte_data;
                endcase
                if (disp_last)
                    state_d = S_OUT;
            end
            S_OUT: if (out_ready) begin
                rec_d   = '0;
                state_d = S_OPCODE;
            end
            default: state_d = S_OPCODE;
        endcase
        if (flush) begin
            state_d = S_OPCODE;
            cnt_d   = 2'd0;
            rec_d   = '0;
        end
    end

    // State, byte counter and record registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_OPCODE;
            cnt_q   <= 2'd0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
        end
    end

endmodule

// File: tb/tb_decode_modrm_collector.sv
// Bench for decode_modrm_collector: 32-bit and 16-bit instances,
// directed instructions plus random ones against a byte-sequence parser.
module tb_decode_modrm_collector;

    typedef struct {
        logic [7:0]  opcode;
        logic        w_in;
        logic        w;
        logic [2:0]  rsc;
        logic        has_modrm;
        logic [1:0]  mod;
        logic [2:0]  rm;
        logic        has_sib;
        logic [7:0]  sib;
        logic [31:0] disp;
        logic [1:0]  dsize;
        logic        illegal;
    } rec_t;

    logic        clk;
    logic        reset_n;
    logic        fl    [2];
    logic        bv    [2];
    logic [7:0]  bd    [2];
    logic        br    [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic [7:0]  op_o  [2];
    logic        win_o [2];
    logic        w_o   [2];
    logic [2:0]  rsc_o [2];
    logic        hm_o  [2];
    logic [1:0]  mod_o [2];
    logic [2:0]  rm_o  [2];
    logic        hs_o  [2];
    logic [7:0]  sib_o [2];
    logic [31:0] dsp_o [2];
    logic [1:0]  dsz_o [2];
    logic        ill_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    decode_modrm_collector #(.ADDRESS_SIZE_32(1'b1)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(fl[0]),
        .byte_valid(bv[0]), .byte_data(bd[0]), .byte_ready(br[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .opcode(op_o[0]),
        .w_in_instruction(win_o[0]), .w(w_o[0]),
        .register_sequence_code(rsc_o[0]), .has_modrm(hm_o[0]),
        .mod(mod_o[0]), .rm(rm_o[0]), .has_sib(hs_o[0]), .sib(sib_o[0]),
        .disp(dsp_o[0]), .disp_size(dsz_o[0]), .illegal(ill_o[0])
    );

    decode_modrm_collector #(.ADDRESS_SIZE_32(1'b0)) dut16 (
        .clk(clk), .reset_n(reset_n), .flush(fl[1]),
        .byte_valid(bv[1]), .byte_data(bd[1]), .byte_ready(br[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .opcode(op_o[1]),
        .w_in_instruction(win_o[1]), .w(w_o[1]),
        .register_sequence_code(rsc_o[1]), .has_modrm(hm_o[1]),
        .mod(mod_o[1]), .rm(rm_o[1]), .has_sib(hs_o[1]), .sib(sib_o[1]),
        .disp(dsp_o[1]), .disp_size(dsz_o[1]), .illegal(ill_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic rec_t mkr(
        input logic [7:0] op, input logic win, input logic ww,
        input logic [2:0] rsc, input logic hm, input logic [1:0] md,
        input logic [2:0] r, input logic hs, input logic [7:0] s,
        input logic [31:0] d, input logic [1:0] ds, input logic ill);
        rec_t x;
        x.opcode = op; x.w_in = win; x.w = ww; x.rsc = rsc;
        x.has_modrm = hm; x.mod = md; x.rm = r; x.has_sib = hs;
        x.sib = s; x.disp = d; x.dsize = ds; x.illegal = ill;
        return x;
    endfunction

    // Parse one instruction from a byte array: record and length.
    function automatic void model(input bit m32, input logic [7:0] b[8],
                                  output rec_t r, output int n);
        logic [7:0]  op;
        logic [1:0]  md;
        logic [2:0]  rr;
        logic [63:0] raw;
        int          nd;
        op = b[0];
        r  = mkr(op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n  = 1;
        nd = 0;
        if ((op < 8'h40 && op % 8 < 4) || (op >= 8'h88 && op <= 8'h8B)) begin
            r.has_modrm = 1;
            r.w_in = 1;
            r.w = op[0];
            md = b[1][7:6];
            rr = b[1][2:0];
            r.mod = md;
            r.rm = rr;
            r.rsc = b[1][5:3];
            n = 2;
            if (m32) begin
                if (md != 3 && rr == 4) begin
                    r.has_sib = 1;
                    r.sib = b[2];
                    n = 3;
                    rr = b[2][2:0];
                end
                if (md == 1) nd = 1;
                else if (md == 2) nd = 4;
                else if (md == 0 && rr == 5) nd = 4;
            end else begin
                if (md == 1) nd = 1;
                else if (md == 2) nd = 2;
                else if (md == 0 && rr == 6) nd = 2;
            end
            raw = 0;
            for (int i = 0; i < nd; i++)
                raw = raw + (64'(b[n + i]) << (8 * i));
            if (nd > 0 && nd < 4 && raw[8 * nd - 1])
                raw = raw - (64'd1 << (8 * nd));
            r.disp = raw[31:0];
            r.dsize = (nd == 4) ? 2'd3 : 2'(nd);
            n = n + nd;
        end else if (op >= 8'h40 && op <= 8'h5F) begin
            r.rsc = op[2:0];
        end else begin
            r.illegal = 1;
        end
    endfunction

    task automatic check_rec(input int k, input rec_t e, input string tag);
        chk({tag, "/op"},   32'(op_o[k]),  32'(e.opcode));
        chk({tag, "/win"},  32'(win_o[k]), 32'(e.w_in));
        chk({tag, "/w"},    32'(w_o[k]),   32'(e.w));
        chk({tag, "/rsc"},  32'(rsc_o[k]), 32'(e.rsc));
        chk({tag, "/hm"},   32'(hm_o[k]),  32'(e.has_modrm));
        chk({tag, "/mod"},  32'(mod_o[k]), 32'(e.mod));
        chk({tag, "/rm"},   32'(rm_o[k]),  32'(e.rm));
        chk({tag, "/hs"},   32'(hs_o[k]),  32'(e.has_sib));
        chk({tag, "/sib"},  32'(sib_o[k]), 32'(e.sib));
        chk({tag, "/disp"}, dsp_o[k],      e.disp);
        chk({tag, "/dsz"},  32'(dsz_o[k]), 32'(e.dsize));
        chk({tag, "/ill"},  32'(ill_o[k]), 32'(e.illegal));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n bytes with random gaps, hold the record, then consume it.
    task automatic send(input int k, input logic [7:0] b[8], input int n,
                        input int hold, input rec_t e, input string tag);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            chk({tag, "/br"}, 32'(br[k]), 1);
            bv[k] = 1'b1;
            bd[k] = b[i];
            tick();
            bv[k] = 1'b0;
        end
        chk({tag, "/ov"}, 32'(ov[k]), 1);
        check_rec(k, e, tag);
        for (int h = 0; h < hold; h++) begin
            bv[k] = 1'b1;
            bd[k] = 8'($urandom);
            tick();
            bv[k] = 1'b0;
            chk({tag, "/hold_ov"}, 32'(ov[k]), 1);
            chk({tag, "/hold_br"}, 32'(br[k]), 0);
            check_rec(k, e, {tag, "/hold"});
        end
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        chk({tag, "/done_ov"}, 32'(ov[k]), 0);
        chk({tag, "/done_br"}, 32'(br[k]), 1);
        chk({tag, "/clr_op"},  32'(op_o[k]), 0);
        chk({tag, "/clr_disp"}, dsp_o[k], 0);
    endtask

    task automatic partial_035078(input int k);
        logic [7:0] p[3];
        p[0] = 8'h03; p[1] = 8'h05; p[2] = 8'h78;
        for (int i = 0; i < 3; i++) begin
            bv[k] = 1'b1;
            bd[k] = p[i];
            tick();
        end
        bv[k] = 1'b0;
    endtask

    logic [7:0] bb[8];
    rec_t       er;
    int         nn;

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fl[k] = 0; bv[k] = 0; bd[k] = 0; ordy[k] = 0;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst/ov", 32'(ov[k]), 0);
            chk("rst/br", 32'(br[k]), 1);
            check_rec(k, mkr(0,0,0,0,0,0,0,0,0,0,0,0), "rst");
        end
        reset_n = 1'b1;
        tick();

        bb = '{8'h01, 8'hC8, 0, 0, 0, 0, 0, 0};
        send(0, bb, 2, 0, mkr(8'h01,1,1,1,1,3,0,0,0,0,0,0), "r031");
        bb = '{8'h8B, 8'h44, 8'h24, 8'h08, 0, 0, 0, 0};
        send(0, bb, 4, 0, mkr(8'h8B,1,1,0,1,1,4,1,8'h24,32'h8,1,0), "r032");
        bb = '{8'h03, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 0, 0};
        send(0, bb, 6, 0,
             mkr(8'h03,1,1,0,1,0,5,0,0,32'h12345678,3,0), "r033a");
        bb = '{8'h8B, 8'h45, 8'hF0, 0, 0, 0, 0, 0};
        send(0, bb, 3, 3,
             mkr(8'h8B,1,1,0,1,1,5,0,0,32'hFFFFFFF0,1,0), "r033b");
        bb = '{8'h8B, 8'h06, 8'h34, 8'h12, 0, 0, 0, 0};
        send(1, bb, 4, 0, mkr(8'h8B,1,1,0,1,0,6,0,0,32'h1234,2,0), "r034a");
        bb = '{8'h8B, 8'h04, 0, 0, 0, 0, 0, 0};
        send(1, bb, 2, 0, mkr(8'h8B,1,1,0,1,0,4,0,0,0,0,0), "r034b");
        bb = '{8'h53, 0, 0, 0, 0, 0, 0, 0};
        send(0, bb, 1, 0, mkr(8'h53,0,0,3,0,0,0,0,0,0,0,0), "r035a");
        bb = '{8'h0F, 0, 0, 0, 0, 0, 0, 0};
        send(0, bb, 1, 1, mkr(8'h0F,0,0,0,0,0,0,0,0,0,0,1), "r035b");
        bb = '{8'h01, 8'hC8, 0, 0, 0, 0, 0, 0};
        send(0, bb, 2, 0, mkr(8'h01,1,1,1,1,3,0,0,0,0,0,0), "r035c");

        partial_035078(0);
        fl[0] = 1'b1;
        bv[0] = 1'b1;
        bd[0] = 8'h01;
        tick();
        fl[0] = 1'b0;
        bv[0] = 1'b0;
        chk("flush/ov", 32'(ov[0]), 0);
        chk("flush/op", 32'(op_o[0]), 0);
        send(0, bb, 2, 0, mkr(8'h01,1,1,1,1,3,0,0,0,0,0,0), "r036f");

        partial_035078(0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst/ov", 32'(ov[0]), 0);
        chk("arst/op", 32'(op_o[0]), 0);
        #1 reset_n = 1'b1;
        tick();
        chk("arst/br", 32'(br[0]), 1);
        send(0, bb, 2, 0, mkr(8'h01,1,1,1,1,3,0,0,0,0,0,0), "r036r");

        for (int t = 0; t < 120; t++) begin
            int k;
            int cat;
            k = t % 2;
            cat = $urandom_range(0, 3);
            for (int i = 0; i < 8; i++)
                bb[i] = 8'($urandom);
            if (cat <= 1) begin
                if ($urandom_range(0, 3) == 0)
                    bb[0] = 8'h88 + 8'($urandom_range(0, 3));
                else
                    bb[0] = 8'($urandom_range(0, 7) * 8 +
                               $urandom_range(0, 3));
            end else if (cat == 2) begin
                bb[0] = 8'h40 + 8'($urandom_range(0, 31));
            end
            model(k == 0, bb, er, nn);
            send(k, bb, nn, $urandom_range(0, 2), er,
                 $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
